// File: rtl/hs_pkg.sv
// Shared definitions for the handshake FIFO and reg-slice blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hs_pkg;

    localparam int HS_DEFAULT_WIDTH = 16;
    localparam int HS_DEFAULT_DEPTH = 4;

    // Per-cycle FIFO operation, encoded as {push, pop}.
    typedef enum logic [1:0] {
        HS_OP_NONE = 2'b00,
        HS_OP_POP  = 2'b01,
        HS_OP_PUSH = 2'b10,
        HS_OP_BOTH = 2'b11
    } hs_op_e;

    function automatic bit hs_is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/hs_sync_fifo_if.sv
// Valid/ready streaming bus between an upstream producer, the FIFO and a downstream consumer.
// Latency: n/a (wires only).
// Backpressure: ready_out stalls the producer, ready_in stalls the FIFO head.
// Ports: valid_in/data_in/ready_out face upstream; valid_out/data_out/ready_in face downstream.
//        master = the environment driving the FIFO, slave = the FIFO itself.
interface hs_sync_fifo_if #(
    parameter int WIDTH = hs_pkg::HS_DEFAULT_WIDTH
);
    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             ready_out;
    logic             valid_out;
    logic [WIDTH-1:0] data_out;
    logic             ready_in;

    modport master (
        output valid_in, data_in, ready_in,
        input  ready_out, valid_out, data_out
    );

    modport slave (
        input  valid_in, data_in, ready_in,
        output ready_out, valid_out, data_out
    );
endinterface

// File: rtl/hs_fifo_mem.sv
// DEPTH x WIDTH register file backing the FIFO; contents are never reset.
// Latency: write lands on the rising edge, read is combinational from the array.
// Backpressure: none; the owner gates the write enable.
// Ports: clk, we/waddr/wdata (synchronous write), raddr/rdata (asynchronous read).
module hs_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/hs_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and threshold flags.
// Latency: a word pushed into an empty FIFO is visible on valid_out/data_out one edge later.
// Backpressure: ready_out drops when full (registered state only); head holds while ready_in is low.
// Ports: clk, rst (async active-low), flush (sync clear), bus (slave side of the handshake bus),
//        count (0..DEPTH), almost_full (count >= AF_LEVEL), almost_empty (count <= AE_LEVEL).
module hs_sync_fifo
    import hs_pkg::*;
#(
    parameter int WIDTH    = HS_DEFAULT_WIDTH,
    parameter int DEPTH    = HS_DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    hs_sync_fifo_if.slave            bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     almost_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);

    if (WIDTH < 1) begin : g_bad_width
        $error("hs_sync_fifo: WIDTH must be at least 1");
    end
    if (DEPTH < 2 || !hs_is_pow2(DEPTH)) begin : g_bad_depth
        $error("hs_sync_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("hs_sync_fifo: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("hs_sync_fifo: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    hs_op_e           op;
    logic [WIDTH-1:0] rd_data;

    // Same slot with opposite wrap bits means the writer is a full lap ahead.
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign push = bus.valid_in && !full;
    assign pop  = bus.ready_in && !empty;
    assign op   = hs_op_e'({push, pop});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Flush wins over any handshake seen this cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (op)
                HS_OP_PUSH: begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    count_d  = count_q + CW'(1);
                end
                HS_OP_POP: begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    count_d  = count_q - CW'(1);
                end
                HS_OP_BOTH: begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
                HS_OP_NONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Memory is left untouched by a flush so a discarded push never lands.
    hs_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    assign bus.ready_out = !full;
    assign bus.valid_out = !empty;
    assign bus.data_out  = empty ? '0 : rd_data;

    assign count        = count_q;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

endmodule

// File: tb/tb_hs_sync_fifo.sv
// Randomised and directed bench for hs_sync_fifo against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_hs_sync_fifo;
    import hs_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       flush_a, flush_b;
    logic [2:0] cnt_a;
    logic [3:0] cnt_b;
    logic       af_a, ae_a, af_b, ae_b;

    hs_sync_fifo_if #(.WIDTH(16)) bus_a ();
    hs_sync_fifo_if #(.WIDTH(16)) bus_b ();

    hs_sync_fifo #(.WIDTH(16), .DEPTH(4)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush_a),
        .bus          (bus_a),
        .count        (cnt_a),
        .almost_full  (af_a),
        .almost_empty (ae_a)
    );

    hs_sync_fifo #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush_b),
        .bus          (bus_b),
        .count        (cnt_b),
        .almost_full  (af_b),
        .almost_empty (ae_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_one(input string tag, input int sz, input logic [15:0] head,
                             input int depth, input int afl, input int ael,
                             input logic rdy, input logic vld, input logic [15:0] dat,
                             input int cnt, input logic af, input logic ae);
        chk({tag, ".count"},     cnt, sz);
        chk({tag, ".ready_out"}, rdy, sz < depth);
        chk({tag, ".valid_out"}, vld, sz != 0);
        chk({tag, ".data_out"},  dat, (sz != 0) ? head : 16'h0);
        chk({tag, ".af"},        af,  sz >= afl);
        chk({tag, ".ae"},        ae,  sz <= ael);
    endtask

    // One clock: check both DUTs against the model, then advance the model by
    // what the current inputs should do at the coming edge.
    task automatic cyc();
        logic        fa, pa, oa, fb, pb, ob;
        logic [15:0] da, db;
        check_one("A", qa.size(), (qa.size() > 0) ? qa[0] : 16'h0, 4, 3, 1,
                  bus_a.ready_out, bus_a.valid_out, bus_a.data_out, int'(cnt_a), af_a, ae_a);
        check_one("B", qb.size(), (qb.size() > 0) ? qb[0] : 16'h0, 8, 6, 2,
                  bus_b.ready_out, bus_b.valid_out, bus_b.data_out, int'(cnt_b), af_b, ae_b);
        fa = flush_a;
        pa = bus_a.valid_in && (qa.size() < 4);
        oa = bus_a.ready_in && (qa.size() > 0);
        da = bus_a.data_in;
        fb = flush_b;
        pb = bus_b.valid_in && (qb.size() < 8);
        ob = bus_b.ready_in && (qb.size() > 0);
        db = bus_b.data_in;
        @(posedge clk);
        #1;
        if (!rst || fa) qa.delete();
        else begin
            if (oa) void'(qa.pop_front());
            if (pa) qa.push_back(da);
        end
        if (!rst || fb) qb.delete();
        else begin
            if (ob) void'(qb.pop_front());
            if (pb) qb.push_back(db);
        end
    endtask

    task automatic idle();
        bus_a.valid_in = 1'b0; bus_a.data_in = '0; bus_a.ready_in = 1'b0; flush_a = 1'b0;
        bus_b.valid_in = 1'b0; bus_b.data_in = '0; bus_b.ready_in = 1'b0; flush_b = 1'b0;
    endtask

    initial begin
        logic [15:0] got[$];
        int          maxc;

        rst = 1'b0;
        idle();
        #2;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();

        // Fill then drain.
        for (int i = 0; i < 4; i++) begin
            bus_a.valid_in = 1'b1; bus_a.data_in = 16'(16 + i);
            cyc();
        end
        bus_a.valid_in = 1'b0;
        chk("fill.count", cnt_a, 4);
        chk("fill.ready_out", bus_a.ready_out, 0);
        chk("fill.af", af_a, 1);
        bus_a.ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain.head%0d", i), {bus_a.valid_out, bus_a.data_out}, {1'b1, 16'(16 + i)});
            cyc();
        end
        chk("drain.empty", {bus_a.valid_out, bus_a.data_out}, 0);

        // Streaming at full throughput.
        maxc = 0;
        got.delete();
        bus_a.valid_in = 1'b1; bus_a.ready_in = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus_a.data_in = 16'(16 + i);
            if (bus_a.valid_out) got.push_back(bus_a.data_out);
            cyc();
            if (int'(cnt_a) > maxc) maxc = int'(cnt_a);
        end
        bus_a.valid_in = 1'b0;
        if (bus_a.valid_out) got.push_back(bus_a.data_out);
        cyc();
        chk("stream.npop", got.size(), 64);
        chk("stream.maxcount", maxc, 1);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("stream.order%0d", i), got[i], 16 + i);
        bus_a.ready_in = 1'b0;

        // Full with ready on both sides.
        for (int i = 0; i < 4; i++) begin
            bus_a.valid_in = 1'b1; bus_a.data_in = 16'(16'h100 + i);
            cyc();
        end
        chk("fullrdy.count0", cnt_a, 4);
        bus_a.ready_in = 1'b1; bus_a.data_in = 16'h200;
        cyc();
        chk("fullrdy.count1", cnt_a, 3);
        chk("fullrdy.ready_out", bus_a.ready_out, 1);
        bus_a.data_in = 16'h201;
        cyc();
        chk("fullrdy.count2", cnt_a, 3);
        chk("fullrdy.head", bus_a.data_out, 16'h102);
        bus_a.valid_in = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        bus_a.ready_in = 1'b0;

        // Flush with a concurrent push.
        for (int i = 0; i < 3; i++) begin
            bus_a.valid_in = 1'b1; bus_a.data_in = 16'(16'h300 + i);
            cyc();
        end
        flush_a = 1'b1; bus_a.data_in = 16'hDEAD;
        cyc();
        flush_a = 1'b0; bus_a.valid_in = 1'b0;
        chk("flush.count", cnt_a, 0);
        chk("flush.valid_out", bus_a.valid_out, 0);
        bus_a.valid_in = 1'b1; bus_a.data_in = 16'h400;
        cyc();
        bus_a.valid_in = 1'b0; bus_a.ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("flush.no_dead", bus_a.data_out == 16'hDEAD, 0);
            cyc();
        end
        bus_a.ready_in = 1'b0;

        // Wrap-around on the deeper FIFO.
        for (int it = 0; it < 3; it++) begin
            bus_b.valid_in = 1'b1; bus_b.ready_in = 1'b0;
            for (int i = 0; i < 8; i++) begin
                bus_b.data_in = 16'($urandom);
                cyc();
            end
            chk($sformatf("wrap.full%0d", it), cnt_b, 8);
            bus_b.valid_in = 1'b0; bus_b.ready_in = 1'b1;
            for (int i = 0; i < 8; i++) cyc();
        end
        bus_b.ready_in = 1'b0;
        chk("wrap.wr_ptr", dut_b.wr_ptr_q, 24 % 16);
        chk("wrap.rd_ptr", dut_b.rd_ptr_q, 24 % 16);

        // Random traffic on both FIFOs.
        for (int i = 0; i < 400; i++) begin
            bus_a.valid_in = 1'($urandom_range(0, 1));
            bus_a.ready_in = 1'($urandom_range(0, 1));
            bus_a.data_in  = 16'($urandom);
            flush_a        = ($urandom_range(0, 15) == 0);
            bus_b.valid_in = ($urandom_range(0, 3) != 0);
            bus_b.ready_in = 1'($urandom_range(0, 1));
            bus_b.data_in  = 16'($urandom);
            flush_b        = ($urandom_range(0, 31) == 0);
            cyc();
        end
        idle();

        // Asynchronous reset mid-stream.
        bus_a.valid_in = 1'b1; bus_b.valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_a.data_in = 16'(16'h500 + i);
            bus_b.data_in = 16'(16'h600 + i);
            cyc();
        end
        #3 rst = 1'b0;
        #1;
        chk("arst.count_a", cnt_a, 0);
        chk("arst.valid_a", bus_a.valid_out, 0);
        chk("arst.ready_a", bus_a.ready_out, 1);
        chk("arst.data_a", bus_a.data_out, 0);
        chk("arst.count_b", cnt_b, 0);
        chk("arst.ae_a", ae_a, 1);
        qa.delete();
        qb.delete();
        cyc();
        cyc();
        rst = 1'b1;
        bus_a.data_in = 16'h1234; bus_a.ready_in = 1'b1;
        bus_b.valid_in = 1'b0;
        cyc();
        bus_a.valid_in = 1'b0;
        chk("arst.first_out", {bus_a.valid_out, bus_a.data_out}, {1'b1, 16'h1234});
        cyc();
        cyc();
        idle();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hs_sync_fifo.md
HS_SYNC_FIFO -- requirements
Module: hs_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 16, data bits per entry; SHALL be at least 1.
REQ-002 Parameter DEPTH, default 4, entry count; SHALL be a power of two and at least 2, with elaboration failing otherwise.
REQ-003 Parameter AF_LEVEL, default DEPTH-1, almost_full threshold; SHALL be in the range 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 1, almost_empty threshold; SHALL be in the range 0..DEPTH-1.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 flush  input  1  synchronous clear, active-high.
REQ-008 valid_in  input  1  upstream data valid.
REQ-009 data_in  input  WIDTH  upstream data.
REQ-010 ready_out  output  1  space available to upstream.
REQ-011 valid_out  output  1  head entry valid to downstream.
REQ-012 data_out  output  WIDTH  head entry data.
REQ-013 ready_in  input  1  downstream ready.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 almost_full, almost_empty  output  1 each  threshold flags.

Function
REQ-016 A push SHALL occur when valid_in and ready_out are both 1, and a pop SHALL occur when valid_out and ready_in are both 1; push and pop SHALL be allowed in the same cycle.
REQ-017 ready_out SHALL equal (count < DEPTH) and SHALL have no combinational path from ready_in, valid_in or data_in.
REQ-018 valid_out SHALL equal (count != 0), and the FIFO SHALL be first-word-fall-through: data_out carries the oldest entry whenever valid_out is 1.
REQ-019 data_out SHALL be driven to 0 whenever valid_out is 0.
REQ-020 Latency: data pushed into an empty FIFO at edge N SHALL appear on valid_out/data_out after edge N, so it is poppable in cycle N+1.
REQ-021 Ordering SHALL be strict FIFO, with no loss or duplication for any valid/ready pattern.
REQ-022 Pointers wr_ptr and rd_ptr SHALL each be $clog2(DEPTH)+1 bits, where the low bits address memory and the MSB is the wrap bit; both SHALL wrap modulo 2*DEPTH.
REQ-023 Full SHALL be detected as equal address bits with differing wrap bits, and empty as fully equal pointers.
REQ-024 count SHALL be a registered value that changes by +1 on push only, by -1 on pop only, and is unchanged on push+pop or on neither.
REQ-025 Full boundary: when count is DEPTH, push SHALL be refused (ready_out=0) even if ready_in=1; a pop that cycle SHALL still occur, and ready_out SHALL rise in the next cycle.
REQ-026 Empty boundary: when count is 0, no pop SHALL occur; a push that cycle SHALL make count 1 in the next cycle.
REQ-027 Simultaneous push and pop at 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-028 almost_full SHALL equal (count >= AF_LEVEL) and almost_empty SHALL equal (count <= AE_LEVEL); both SHALL be decoded from registered state only.
REQ-029 When flush=1 at a rising edge, pointers and count SHALL become 0, overriding any push or pop in that cycle.
REQ-030 During a flush cycle, a handshake that appears to complete SHALL be discarded, and memory contents SHALL be left untouched.

Reset
REQ-031 Assertion of rst SHALL immediately, without a clock, force wr_ptr=0, rd_ptr=0 and count=0.
REQ-032 While rst is asserted, outputs SHALL be ready_out=1, valid_out=0, data_out=0, almost_full=(AF_LEVEL==0 ? 1 : 0) and almost_empty=1.
REQ-033 Memory array contents SHALL not be reset.
REQ-034 Reset asserted mid-transfer SHALL discard all stored entries, and no pop SHALL be reported after reset releases.
REQ-035 Reset deassertion SHALL be effective from the first rising edge after release.

Structure
REQ-036 Package hs_pkg SHALL hold HS_DEFAULT_WIDTH=16 and HS_DEFAULT_DEPTH=4, shared with the reg-slice blocks.
REQ-037 Pointer and count widths SHALL be module localparams derived from DEPTH.
REQ-038 Sub-module hs_fifo_mem SHALL be a DEPTH x WIDTH register file with a synchronous write port and an asynchronous read port.
REQ-039 The hs_sync_fifo top level SHALL own the pointers, count, flags and handshake logic.

Verification
REQ-040 Fill/drain (DEPTH=4): push 16,17,18,19 with ready_in=0 -> count=4, ready_out=0, almost_full=1; then ready_in=1 -> pops 16..19 in four consecutive cycles, after which valid_out=0 and data_out=0.
REQ-041 Streaming (DEPTH=4): valid_in=1 and ready_in=1 for 64 cycles with data 16..79 -> outputs 16..79 in order, first on the cycle after the first push, and count never exceeds 1.
REQ-042 Full with simultaneous ready (count=4): valid_in=1 and ready_in=1 -> one pop and no push, count=3; next cycle count stays 3 while pushes and pops continue.
REQ-043 Wrap-around (DEPTH=8): 3 iterations of 8 pushes then 8 pops with random data -> all data matches a scoreboard and pointers wrap twice.
REQ-044 Flush: flush=1 with count=3 and valid_in=1 -> count=0 and valid_out=0 next cycle, and the pushed word is never output.
REQ-045 Async reset: rst low mid-stream between clock edges -> count=0, valid_out=0 and ready_out=1 before the next edge, and after release the next push is output first.
